imem_fetch_controller: RTL

//  Sequences the 64-word instruction memory: boot-loads a program through a

---
 rtl/imem_fetch_controller.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/imem_fetch_controller.sv
`default_nettype none
// ============================================================================
//  Module  : imem_fetch_controller
//  Purpose : Sequences a 64-word instruction memory. Boot-loads a program
//            through a valid/ready word stream, then runs the fetch stage of
//            a 5-stage pipeline: owns the PC and the IF/ID instruction
//            register, applies stall and branch redirect, and stops on a
//            halt word.
//  Ports   : clk, reset (async, active-high)
//            load_start/load_valid/load_ready/load_data/load_last : loader
//            mem_addr/mem_we/mem_wdata/mem_rdata : single-port memory bus
//            run/stall/branch_taken/branch_target : pipeline control
//            pc/if_instruction/if_valid : fetch outputs
//            load_count/busy/halted : status
//  Revision: 1.0  initial release
// ============================================================================
module imem_fetch_controller #(
    parameter int ADDR_W                 = 6,
    parameter int DATA_W                 = 32,
    parameter int DEPTH                  = 64,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFC000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              run,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] if_instruction,
    output logic              if_valid,
    output logic [ADDR_W:0]   load_count,
    output logic              busy,
    output logic              halted
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_run  = 2'd2;
    localparam logic [1:0] c_st_halt = 2'd3;

    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   c_count_one = (ADDR_W + 1)'(1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_load_ptr;
    logic [DATA_W-1:0] r_if_instruction;
    logic              r_if_valid;
    logic [ADDR_W:0]   r_load_count;

    logic w_in_load;
    logic w_accept;
    logic w_load_done;

    assign w_in_load   = (r_state == c_st_load);
    assign w_accept    = w_in_load && load_valid;
    // The last slot ends the load even without load_last, so no write can
    // ever wrap back over address 0.
    assign w_load_done = w_accept && (load_last || (r_load_ptr == c_last_addr));

    // Outputs
    assign load_ready     = w_in_load;
    assign mem_we         = w_accept;
    assign mem_wdata      = load_data;
    assign mem_addr       = w_in_load ? r_load_ptr : r_pc;
    assign pc             = r_pc;
    assign if_instruction = r_if_instruction;
    assign if_valid       = r_if_valid;
    assign load_count     = r_load_count;
    assign busy           = (r_state != c_st_idle);
    assign halted         = (r_state == c_st_halt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= c_st_idle;
            r_pc             <= '0;
            r_load_ptr       <= '0;
            r_if_instruction <= '0;
            r_if_valid       <= 1'b0;
            r_load_count     <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (load_start) begin
                        r_state    <= c_st_load;
                        r_load_ptr <= '0;
                    end else if (run) begin
                        r_state    <= c_st_run;
                        r_pc       <= '0;
                        r_if_valid <= 1'b0;
                    end
                end

                c_st_load: begin
                    if (w_accept) begin
                        r_load_ptr <= r_load_ptr + c_addr_one;
                    end
                    if (w_load_done) begin
                        r_state      <= c_st_idle;
                        r_load_count <= {1'b0, r_load_ptr} + c_count_one;
                    end
                end

                c_st_run: begin
                    if (!run) begin
                        r_state    <= c_st_idle;
                        r_if_valid <= 1'b0;
                    end else if (branch_taken) begin
                        // Redirect beats stall: the word fetched this cycle
                        // is on the wrong path, so insert one bubble.
                        r_pc       <= branch_target;
                        r_if_valid <= 1'b0;
                    end else if (!stall) begin
                        r_if_instruction <= mem_rdata;
                        r_if_valid       <= 1'b1;
                        if (mem_rdata == HALT_WORD) begin
                            r_state <= c_st_halt;
                        end else begin
                            r_pc <= r_pc + c_addr_one;
                        end
                    end
                end

                c_st_halt: begin
                    // The halt word itself is presented for exactly one cycle.
                    r_if_valid <= 1'b0;
                    if (!run) begin
                        r_state <= c_st_idle;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
